// File: rtl/fetch_pkg.sv
// Shared types and constants for the lab-CPU instruction-fetch stage.
// Optional instruction counter in fetch_unit is enabled by defining INSTR_COUNT_EN.
package fetch_pkg;

    localparam int PC_W_DEFAULT    = 8;
    localparam int LABEL_N_DEFAULT = 16;
    localparam int LABEL_IDX_W     = $clog2(LABEL_N_DEFAULT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        HALTED
    } fetch_state_t;

    // Decoder opcodes (upper nibble of the instruction byte).
    localparam logic [3:0] OP_BEQ0 = 4'b0110;
    localparam logic [3:0] OP_J    = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1110;

endpackage

// File: rtl/label_table.sv
// Branch label table: LABEL_N entries of PC_W bits, one synchronous write port,
// one combinational read port; the whole table clears on reset.
module label_table
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int LABEL_N = LABEL_N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en_i,
    input  logic [LABEL_IDX_W-1:0] wr_idx_i,
    input  logic [PC_W-1:0]        wr_addr_i,
    input  logic [LABEL_IDX_W-1:0] rd_idx_i,
    output logic [PC_W-1:0]        rd_addr_o
);

    logic [PC_W-1:0] entry_q [LABEL_N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LABEL_N; i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            entry_q[wr_idx_i] <= wr_addr_i;
        end
    end

    // Reads the stored value, so a same-cycle write is seen only next cycle.
    assign rd_addr_o = entry_q[rd_idx_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ROM sequencing, instruction register and next-PC select.
// Define INSTR_COUNT_EN to add the saturating retired-instruction counter instr_count_o.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int LABEL_N = LABEL_N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic [PC_W-1:0]        imem_addr_o,
    input  logic [7:0]             imem_data_i,
    output logic [7:0]             instr_o,
    output logic                   instr_valid_o,
    input  logic                   stall_i,
    input  logic                   label_read_i,
    input  logic                   branch_i,
    input  logic                   zero_i,
    input  logic [LABEL_IDX_W-1:0] branch_addr_i,
    input  logic                   halt_i,
    input  logic                   label_wr_en_i,
    input  logic [LABEL_IDX_W-1:0] label_wr_idx_i,
    input  logic [PC_W-1:0]        label_wr_addr_i,
    output logic [PC_W-1:0]        pc_o,
    output logic                   halted_o
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]            instr_count_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      instr_q, instr_d;
    logic [PC_W-1:0] label_target;
    logic            taken;

    label_table #(
        .PC_W    (PC_W),
        .LABEL_N (LABEL_N)
    ) u_label_table (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (label_wr_en_i),
        .wr_idx_i  (label_wr_idx_i),
        .wr_addr_i (label_wr_addr_i),
        .rd_idx_i  (branch_addr_i),
        .rd_addr_o (label_target)
    );

    // j is unconditional; beq0 needs the ALU zero flag.
    assign taken = label_read_i && (!branch_i || zero_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                instr_d = imem_data_i;
                state_d = EXEC;
            end
            EXEC: begin
                if (stall_i) begin
                    state_d = EXEC;
                end else if (halt_i) begin
                    state_d = HALTED;
                end else begin
                    state_d = FETCH;
                    pc_d    = taken ? label_target : pc_q + PC_W'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ROM address is simply the PC; it is only meaningful to the ROM during FETCH.
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == EXEC);
    assign halted_o      = (state_q == HALTED);

`ifdef INSTR_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == EXEC && !stall_i && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count_o = count_q;
`endif

endmodule
